// File: rtl/inst_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// inst_mem_arbiter_if
// Bundles the three buses handled by the instruction-memory arbiter:
//   - fetch port : if_req/if_addr in, if_ack/if_inst/stallreq out
//   - debug port : dbg_req/dbg_we/dbg_addr/dbg_wdata in, dbg_ack/dbg_rdata out
//   - memory port: mem_ce/mem_we/mem_addr/mem_wdata out, mem_rdata in
// The slave modport is the arbiter's view; the master modport is the view of
// the requesters plus the memory that surround it.
// -----------------------------------------------------------------------------
interface inst_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_inst;
  logic              stallreq;

  // debug / loader port
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  // memory port
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output if_ack, if_inst, stallreq, dbg_ack, dbg_rdata,
           mem_ce, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  if_ack, if_inst, stallreq, dbg_ack, dbg_rdata,
           mem_ce, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/inst_mem_arbiter.sv
// -----------------------------------------------------------------------------
// inst_mem_arbiter
// Shares one single-port instruction memory between the fetch stage and a
// debug/loader port. Each access takes two cycles (ACCESS then RESP); a
// request seen on the RESP-exit edge starts the next access immediately, so
// a held request streams at one access every two cycles.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous, active-low reset
//   bus  - inst_mem_arbiter_if.slave (fetch, debug and memory buses)
// -----------------------------------------------------------------------------
module inst_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  inst_mem_arbiter_if.slave   bus
);

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  state_e            state_q,      state_d;
  owner_e            owner_q,      owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              if_ack_q,     if_ack_d;
  logic              dbg_ack_q,    dbg_ack_d;
  logic [DATA_W-1:0] if_inst_q,    if_inst_d;
  logic [DATA_W-1:0] dbg_rdata_q,  dbg_rdata_d;
  logic              mem_ce_q,     mem_ce_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;

  // Round-robin pick: a lone requester wins; on a tie the one that did not
  // win last time gets the grant.
  function automatic owner_e pick_winner(input logic   if_req,
                                         input logic   dbg_req,
                                         input owner_e last);
    owner_e win;
    if (if_req && dbg_req) begin
      win = (last == OWN_DBG) ? OWN_IF : OWN_DBG;
    end else if (dbg_req) begin
      win = OWN_DBG;
    end else begin
      win = OWN_IF;
    end
    return win;
  endfunction

  // Next-state and output logic for the IDLE/ACCESS/RESP controller.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    if_ack_d     = 1'b0;
    dbg_ack_d    = 1'b0;
    if_inst_d    = if_inst_q;
    dbg_rdata_d  = dbg_rdata_q;
    mem_ce_d     = mem_ce_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE, S_RESP: begin
        mem_ce_d = CHIP_DISABLE;
        mem_we_d = 1'b0;
        if (bus.if_req || bus.dbg_req) begin
          state_d      = S_ACCESS;
          owner_d      = pick_winner(bus.if_req, bus.dbg_req, last_owner_q);
          last_owner_d = owner_d;
          mem_ce_d     = CHIP_ENABLE;
          if (owner_d == OWN_DBG) begin
            mem_we_d    = bus.dbg_we;
            mem_addr_d  = bus.dbg_addr;
            mem_wdata_d = bus.dbg_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ACCESS: begin
        // The access completes on the latched address even if the request
        // has since dropped; mem_rdata is valid this cycle.
        state_d  = S_RESP;
        mem_ce_d = CHIP_DISABLE;
        mem_we_d = 1'b0;
        if (owner_q == OWN_IF) begin
          if_ack_d  = 1'b1;
          if_inst_d = bus.mem_rdata;
        end else begin
          dbg_ack_d = 1'b1;
          if (!mem_we_q) begin
            dbg_rdata_d = bus.mem_rdata;
          end else begin
            dbg_rdata_d = dbg_rdata_q;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        mem_ce_d = CHIP_DISABLE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces everything to the idle values
  // at once, which also kills any write in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_DBG;
      if_ack_q     <= 1'b0;
      dbg_ack_q    <= 1'b0;
      if_inst_q    <= {DATA_W{1'b0}};
      dbg_rdata_q  <= {DATA_W{1'b0}};
      mem_ce_q     <= CHIP_DISABLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      if_ack_q     <= if_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      if_inst_q    <= if_inst_d;
      dbg_rdata_q  <= dbg_rdata_d;
      mem_ce_q     <= mem_ce_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  // Combinational so the pipeline stops in the same cycle the fetch is pending.
  assign bus.stallreq  = bus.if_req & ~if_ack_q;

endmodule

// File: doc/inst_mem_arbiter.md
INST_MEM_ARBITER -- requirements
Module: inst_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, instruction/data word width in bits.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: if_req  input  1  fetch-stage read request; held until if_ack.
REQ-006 Port: if_addr  input  ADDR_W  fetch byte address; stable while if_req high.
REQ-007 Port: if_ack  output  1  one-cycle pulse; if_inst valid this cycle.
REQ-008 Port: if_inst  output  DATA_W  fetched instruction, registered, held between acks.
REQ-009 Port: stallreq  output  1  stall request to the pipeline controller.
REQ-010 Port: dbg_req  input  1  debug/loader request; held until dbg_ack.
REQ-011 Port: dbg_we  input  1  debug write (1) or read (0); stable while dbg_req high.
REQ-012 Port: dbg_addr  input  ADDR_W  debug byte address.
REQ-013 Port: dbg_wdata  input  DATA_W  debug write data.
REQ-014 Port: dbg_ack  output  1  one-cycle pulse; access complete, dbg_rdata valid on reads.
REQ-015 Port: dbg_rdata  output  DATA_W  debug read data, registered, held between read acks.
REQ-016 Port: mem_ce  output  1  memory chip enable, ChipEnable during an access only.
REQ-017 Port: mem_we  output  1  memory write enable.
REQ-018 Port: mem_addr  output  ADDR_W  memory byte address, passed unmodified (memory selects word by addr[..:2]).
REQ-019 Port: mem_wdata  output  DATA_W  memory write data.
REQ-020 Port: mem_rdata  input  DATA_W  memory read data, combinational from mem_addr within the same cycle.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, RESP; mem_* outputs and owner SHALL be registered at entry to ACCESS.
REQ-022 IDLE or RESP with any request sampled high SHALL go to ACCESS with winner latched; otherwise SHALL go to IDLE.
REQ-023 ACCESS SHALL always go to RESP; at that edge mem_rdata SHALL be captured into if_inst (owner IF) or dbg_rdata (owner DBG, read), and the owner's ack SHALL be set.
REQ-024 In RESP the owner's ack SHALL be high for exactly one cycle, and mem_ce, mem_we SHALL be deasserted.
REQ-025 Latency: request first high at edge E0 yields ack high in the cycle after E1 (2 cycles); sustained throughput SHALL be one access per 2 cycles.
REQ-026 A requester's req sampled at the RESP-exit edge SHALL be treated as its next request (the requester updates address during the ack cycle).
REQ-027 Arbitration: single requester wins; both requesting SHALL grant the requester not in last_owner (round-robin); last_owner SHALL update on every grant.
REQ-028 IF accesses SHALL drive mem_we=0; DBG accesses SHALL drive mem_we=dbg_we, mem_wdata=dbg_wdata.
REQ-029 Debug writes SHALL pulse dbg_ack and leave dbg_rdata unchanged.
REQ-030 Request dropped during ACCESS SHALL not abort: access completes on the latched address, and ack still pulses.
REQ-031 stallreq SHALL equal if_req AND NOT if_ack (combinational).
REQ-032 if_ack and dbg_ack SHALL never be high in the same cycle.

Reset
REQ-033 rst low SHALL immediately force state=IDLE, if_ack=0, dbg_ack=0, if_inst=0, dbg_rdata=0, mem_ce=ChipDisable, mem_we=0, mem_addr=0, mem_wdata=0, last_owner=DBG (IF wins first tie).
REQ-034 Reset asserted mid-ACCESS SHALL discard the access without ack; a write in flight SHALL be dropped (mem_we low immediately).
REQ-035 First grant SHALL occur at the first rising edge after rst deasserts with a request high.

Verification
REQ-036 Single fetch: mem word 0x00000004 = 0x3C010101, if_req=1, if_addr=0x4 -> mem_ce in cycle 1, if_ack and if_inst=0x3C010101 in cycle 2; stallreq high cycles 0-1.
REQ-037 Streaming fetch: if_req held, addresses 0x0,0x4,0x8 advanced on each ack -> acks every 2nd cycle with matching words, no gaps.
REQ-038 Contention: if_req and dbg_req both high from reset release -> grants IF, DBG, IF, DBG alternating; no cycle with both acks.
REQ-039 Debug write then fetch: dbg write 0xDEADBEEF to 0x10, then if_addr=0x10 -> mem_we=1 exactly one cycle, if_inst=0xDEADBEEF, dbg_rdata unchanged.
REQ-040 Reset mid-access: rst low during ACCESS of a dbg write -> mem_we/mem_ce drop same cycle, no dbg_ack, all outputs at REQ-033 values.
